ps2_key_fifo: RTL and testbench
===============================

// Module: ps2_key_fifo
// PURPOSE
//  PS/2 keyboard receiver + key-event FIFO; upstream of MIO_BUS key port in Multi_SOC.
//  Samples raw PS2_clk/PS2_data, deframes 11-bit frames, folds E0/F0 prefixes into one
//  16-bit key event, buffers events for the CPU, which pops one per bus read.
// PARAMETERS
//  DEPTH    8      FIFO entries (power of 2, >=2)
//  AW       3      log2(DEPTH)
//  TIMEOUT  50000  clk cycles with no PS2_clk fall mid-frame before abort (1 ms @ 50 MHz)
// PORTS
//  clk          in   1   system clock (Div[0], 50 MHz)
//  RSTN         in   1   asynchronous active-low reset
//  PS2_clk      in   1   raw keyboard clock (asynchronous)
//  PS2_data     in   1   raw keyboard data (asynchronous)
//  rd_en        in   1   pop strobe from MIO_BUS, one cycle per read
//  key          out  16  FIFO head: {brk, ext, 6'b0, code[7:0]}
//  key_valid    out  1   FIFO not empty
//  fifo_cnt     out  AW+1 entries held, 0..DEPTH
//  overflow     out  1   sticky: an event was dropped because FIFO full
//  frame_err    out  1   one-cycle pulse: bad start/parity/stop or timeout
// BEHAVIOUR
//  Reset: all outputs 0, FSM IDLE, ext/brk flags 0, FIFO empty, pointers 0.
//  Input sync: PS2_clk, PS2_data each through 2 flops; fall = prev sync clk 1, now 0.
//  All bit sampling on fall only; data value taken from synced PS2_data same cycle.
//  FSM: IDLE -fall,data=0-> DATA; IDLE -fall,data=1-> IDLE (no err).
//   DATA: 8 falls, LSB first into shift reg -> PARITY; PARITY: 1 fall -> STOP;
//   STOP: 1 fall -> IDLE; frame good if stop=1 and ^{code,parity}=1 (odd).
//  Timeout: counter cleared on each fall, counts in non-IDLE; reaching TIMEOUT ->
//   IDLE, frame discarded, frame_err pulse, ext/brk cleared.
//  Bad parity or stop=0: frame discarded, frame_err pulse, ext/brk cleared.
//  Good frame: code 8'hE0 sets ext; 8'hF0 sets brk; neither pushed.
//   Any other code: push {brk,ext,6'b0,code} on cycle after STOP fall; clear ext/brk.
//  Latency: stop-bit fall (synced) -> key_valid high 2 clk later when FIFO was empty.
//  FIFO first-word-fall-through: key = mem[rd_ptr] whenever key_valid; key holds last
//   head value when empty (not cleared).
//  rd_en while empty: ignored, no state change. Pointers wrap modulo DEPTH.
//  Push while full without same-cycle pop: event dropped, overflow set to 1.
//  Push and pop same cycle: both performed, fifo_cnt unchanged (full case: no drop).
//  overflow cleared only by rd_en or reset.
//  RSTN low mid-frame: frame lost, everything to reset values immediately.
// CONFIGURATION
//  PS2_BREAK_FILTER_EN defined: events with brk=1 are never pushed (make codes only);
//   F0 still consumed and clears after next code.
//  Not defined: break events pushed with key[15]=1 as described above.
// TESTING
//  Frame 0x1C (A), parity 0 -> key=16'h001C, key_valid=1, fifo_cnt=1, no frame_err.
//  F0,1C -> key=16'h801C (16'h0000 count 0 if PS2_BREAK_FILTER_EN); E0,F0,75 -> 16'hC075.
//  Frame 0x1C with parity bit 1 -> frame_err one pulse, fifo_cnt stays 0.
//  Start bit + 4 bits then PS2_clk idle 50000 cycles -> frame_err, FSM IDLE; next 0x29 ok.
//  9 codes 0x01..0x09, no reads -> fifo_cnt=8, overflow=1, head 16'h0001; 8 pops give
//   01..08, then key_valid=0; rd_en with cnt 8 + push same cycle -> cnt 8, no drop.
//  RSTN pulse after 5 data bits -> all outputs 0; following frame 0x5A -> key=16'h005A.

Source files
------------

// File: rtl/ps2_key_fifo.sv
// rtl/ps2_key_fifo.sv - PS/2 keyboard receiver folding E0/F0 prefixes into key events buffered in a FWFT FIFO
// Optional build macro: PS2_BREAK_FILTER_EN (when defined, break events are consumed but never queued)
module ps2_key_fifo #(
    parameter int DEPTH   = 8,
    parameter int AW      = 3,
    parameter int TIMEOUT = 50000
) (
    input  logic          clk,
    input  logic          RSTN,
    input  logic          PS2_clk,
    input  logic          PS2_data,
    input  logic          rd_en,
    output logic [15:0]   key,
    output logic          key_valid,
    output logic [AW:0]   fifo_cnt,
    output logic          overflow,
    output logic          frame_err
);

    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

    // Synchronizers; reset to 1 so the idle-high bus never looks like a fall
    logic          pclk_s1_q, pclk_s1_d, pclk_s2_q, pclk_s2_d, pclk_prev_q, pclk_prev_d;
    logic          pdat_s1_q, pdat_s1_d, pdat_s2_q, pdat_s2_d;

    // Deframer
    state_t        state_q, state_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          par_q, par_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          ext_q, ext_d, brk_q, brk_d;
    logic          push_q, push_d;
    logic [15:0]   push_data_q, push_data_d;
    logic          err_q, err_d;

    // FIFO
    logic [15:0]   mem_q [DEPTH];
    logic [15:0]   mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic [15:0]   key_q, key_d;
    logic          ovf_q, ovf_d;

    logic          fall;
    logic          pop, full, wr, drop;

    assign fall      = pclk_prev_q & ~pclk_s2_q;
    assign key       = key_q;
    assign key_valid = (cnt_q != '0);
    assign fifo_cnt  = cnt_q;
    assign overflow  = ovf_q;
    assign frame_err = err_q;

    // Input synchronizer next-state
    always_comb begin
        pclk_s1_d   = PS2_clk;
        pclk_s2_d   = pclk_s1_q;
        pclk_prev_d = pclk_s2_q;
        pdat_s1_d   = PS2_data;
        pdat_s2_d   = pdat_s1_q;
    end

    // Frame deframer, prefix folding and inactivity timeout
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        par_d       = par_q;
        tmo_d       = tmo_q;
        ext_d       = ext_q;
        brk_d       = brk_q;
        push_d      = 1'b0;
        push_data_d = push_data_q;
        err_d       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (fall && !pdat_s2_q) begin
                    state_d   = S_DATA;
                    bit_cnt_d = 3'd0;
                end
            end
            S_DATA: begin
                if (fall) begin
                    shift_d   = {pdat_s2_q, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = S_PARITY;
                    end
                end
            end
            S_PARITY: begin
                if (fall) begin
                    par_d   = pdat_s2_q;
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (fall) begin
                    state_d = S_IDLE;
                    if (pdat_s2_q && (^{shift_q, par_q})) begin
                        if (shift_q == 8'hE0) begin
                            ext_d = 1'b1;
                        end else if (shift_q == 8'hF0) begin
                            brk_d = 1'b1;
                        end else begin
`ifdef PS2_BREAK_FILTER_EN
                            push_d = ~brk_q;
`else
                            push_d = 1'b1;
`endif
                            push_data_d = {brk_q, ext_q, 6'b0, shift_q};
                            ext_d       = 1'b0;
                            brk_d       = 1'b0;
                        end
                    end else begin
                        err_d = 1'b1;
                        ext_d = 1'b0;
                        brk_d = 1'b0;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Timeout only runs mid-frame; any fall restarts it
        if (state_q == S_IDLE || fall) begin
            tmo_d = '0;
        end else if (tmo_q == TW'(TIMEOUT - 1)) begin
            tmo_d   = '0;
            state_d = S_IDLE;
            err_d   = 1'b1;
            ext_d   = 1'b0;
            brk_d   = 1'b0;
        end else begin
            tmo_d = tmo_q + TW'(1);
        end
    end

    // FIFO bookkeeping; key register tracks the head and holds when empty
    always_comb begin
        pop  = rd_en && (cnt_q != '0);
        full = (cnt_q == (AW+1)'(DEPTH));
        wr   = push_q && (!full || pop);
        drop = push_q && full && !pop;

        mem_d = mem_q;
        if (wr) begin
            mem_d[wr_ptr_q] = push_data_q;
        end
        wr_ptr_d = wr ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;

        cnt_d = cnt_q;
        if (wr && !pop) begin
            cnt_d = cnt_q + (AW+1)'(1);
        end else if (pop && !wr) begin
            cnt_d = cnt_q - (AW+1)'(1);
        end

        key_d = (cnt_d != '0) ? mem_d[rd_ptr_d] : key_q;

        if (rd_en) begin
            ovf_d = 1'b0;
        end else if (drop) begin
            ovf_d = 1'b1;
        end else begin
            ovf_d = ovf_q;
        end
    end

    // State registers
    always_ff @(posedge clk or negedge RSTN) begin
        if (!RSTN) begin
            pclk_s1_q   <= 1'b1;
            pclk_s2_q   <= 1'b1;
            pclk_prev_q <= 1'b1;
            pdat_s1_q   <= 1'b1;
            pdat_s2_q   <= 1'b1;
            state_q     <= S_IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            par_q       <= 1'b0;
            tmo_q       <= '0;
            ext_q       <= 1'b0;
            brk_q       <= 1'b0;
            push_q      <= 1'b0;
            push_data_q <= '0;
            err_q       <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
            key_q       <= '0;
            ovf_q       <= 1'b0;
        end else begin
            pclk_s1_q   <= pclk_s1_d;
            pclk_s2_q   <= pclk_s2_d;
            pclk_prev_q <= pclk_prev_d;
            pdat_s1_q   <= pdat_s1_d;
            pdat_s2_q   <= pdat_s2_d;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            par_q       <= par_d;
            tmo_q       <= tmo_d;
            ext_q       <= ext_d;
            brk_q       <= brk_d;
            push_q      <= push_d;
            push_data_q <= push_data_d;
            err_q       <= err_d;
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
            key_q       <= key_d;
            ovf_q       <= ovf_d;
        end
    end

endmodule

// File: tb/tb_ps2_key_fifo.sv
// tb/tb_ps2_key_fifo.sv - directed self-checking bench for ps2_key_fifo
module tb_ps2_key_fifo;

    logic        clk = 1'b0;
    logic        RSTN = 1'b0;
    logic        PS2_clk = 1'b1;
    logic        PS2_data = 1'b1;
    logic        rd_en = 1'b0;
    logic [15:0] key;
    logic        key_valid;
    logic [3:0]  fifo_cnt;
    logic        overflow;
    logic        frame_err;

    int n_chk  = 0;
    int n_pass = 0;
    int err_cnt = 0;

    ps2_key_fifo dut (
        .clk       (clk),
        .RSTN      (RSTN),
        .PS2_clk   (PS2_clk),
        .PS2_data  (PS2_data),
        .rd_en     (rd_en),
        .key       (key),
        .key_valid (key_valid),
        .fifo_cnt  (fifo_cnt),
        .overflow  (overflow),
        .frame_err (frame_err)
    );

    always #10 clk = ~clk;

    always @(negedge clk) begin
        if (frame_err === 1'b1) err_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // mode 0: plain, 1: pulse rd_en in the push cycle, 2: check 2-cycle key_valid latency
    task automatic send_bit(input logic b, input int mode);
        @(negedge clk);
        PS2_data = b;
        repeat (4) @(negedge clk);
        PS2_clk = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (mode == 1 && i == 3) rd_en = 1'b1;
            if (mode == 1 && i == 4) rd_en = 1'b0;
            if (mode == 2 && i == 3) check("latency_lo", key_valid, 0);
            if (mode == 2 && i == 4) check("latency_hi", key_valid, 1);
        end
        PS2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] code, input logic bad_par, input int mode);
        logic par;
        par = ~(^code) ^ bad_par;
        send_bit(1'b0, 0);
        for (int i = 0; i < 8; i++) send_bit(code[i], 0);
        send_bit(par, 0);
        send_bit(1'b1, mode);
        repeat (4) @(negedge clk);
    endtask

    task automatic pop_expect(input string tag, input logic [15:0] exp);
        @(negedge clk);
        check(tag, key, exp);
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    initial begin
        int e0;
        int waited;
        repeat (3) @(negedge clk);
        check("rst_key", key, 0);
        check("rst_valid", key_valid, 0);
        check("rst_cnt", fifo_cnt, 0);
        check("rst_ovf", overflow, 0);
        check("rst_err", frame_err, 0);
        RSTN = 1'b1;
        repeat (4) @(negedge clk);

        // Single make code, with latency check
        send_frame(8'h1C, 1'b0, 2);
        check("a_key", key, 16'h001C);
        check("a_cnt", fifo_cnt, 1);
        check("a_err", err_cnt, 0);
        pop_expect("a_pop", 16'h001C);
        @(negedge clk);
        check("a_empty", key_valid, 0);
        check("a_hold", key, 16'h001C);

        // Break and extended break
        send_frame(8'hF0, 1'b0, 0);
        send_frame(8'h1C, 1'b0, 0);
`ifdef PS2_BREAK_FILTER_EN
        check("brk_cnt", fifo_cnt, 0);
`else
        check("brk_cnt", fifo_cnt, 1);
        pop_expect("brk_key", 16'h801C);
`endif
        send_frame(8'hE0, 1'b0, 0);
        send_frame(8'hF0, 1'b0, 0);
        send_frame(8'h75, 1'b0, 0);
`ifndef PS2_BREAK_FILTER_EN
        pop_expect("extbrk_key", 16'hC075);
`endif
        check("extbrk_empty", fifo_cnt, 0);

        // Bad parity
        e0 = err_cnt;
        send_frame(8'h1C, 1'b1, 0);
        check("par_err", err_cnt - e0, 1);
        check("par_cnt", fifo_cnt, 0);

        // Timeout mid-frame
        e0 = err_cnt;
        for (int i = 0; i < 5; i++) send_bit(1'b0, 0);
        waited = 0;
        while (err_cnt == e0 && waited < 60000) begin
            @(negedge clk);
            waited++;
        end
        check("tmo_err", err_cnt - e0, 1);
        check("tmo_wait_ok", (waited > 49000) && (waited < 60000), 1);
        send_frame(8'h29, 1'b0, 0);
        check("tmo_next_key", key, 16'h0029);
        pop_expect("tmo_pop", 16'h0029);

        // rd_en on empty FIFO
        @(negedge clk) rd_en = 1'b1;
        @(negedge clk) rd_en = 1'b0;
        @(negedge clk);
        check("rd_empty_cnt", fifo_cnt, 0);
        check("rd_empty_key", key, 16'h0029);

        // Overflow
        for (int c = 1; c <= 9; c++) send_frame(8'(c), 1'b0, 0);
        check("ovf_cnt", fifo_cnt, 8);
        check("ovf_flag", overflow, 1);
        check("ovf_head", key, 16'h0001);
        for (int c = 1; c <= 8; c++) pop_expect("ovf_pop", 16'(c));
        @(negedge clk);
        check("ovf_drained", key_valid, 0);
        check("ovf_cleared", overflow, 0);

        // Full FIFO with push and pop in the same cycle
        for (int c = 8'h11; c <= 8'h18; c++) send_frame(8'(c), 1'b0, 0);
        check("full_cnt", fifo_cnt, 8);
        send_frame(8'h19, 1'b0, 1);
        check("pp_cnt", fifo_cnt, 8);
        check("pp_ovf", overflow, 0);
        for (int c = 8'h12; c <= 8'h19; c++) pop_expect("pp_pop", 16'(c));
        check("pp_empty", fifo_cnt, 0);

        // Reset mid-frame
        send_frame(8'h33, 1'b0, 0);
        for (int i = 0; i < 6; i++) send_bit(1'b1 ^ (i == 0), 0);
        @(negedge clk);
        RSTN = 1'b0;
        #1;
        check("mid_rst_key", key, 0);
        check("mid_rst_valid", key_valid, 0);
        check("mid_rst_cnt", fifo_cnt, 0);
        repeat (2) @(negedge clk);
        RSTN = 1'b1;
        repeat (4) @(negedge clk);
        send_frame(8'h5A, 1'b0, 0);
        check("post_rst_key", key, 16'h005A);
        check("post_rst_cnt", fifo_cnt, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
